ddram_port_arbiter: RTL and testbench

// - Shares the single MiSTer DDRAM port among the four memory requesters of the LM-3 core:

---
 rtl/ddram_port_arbiter_pkg.sv | 23 ++
 rtl/ddram_port_arbiter_rr_pick3.sv | 26 ++
 rtl/ddram_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_ddram_port_arbiter.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddram_port_arbiter_pkg.sv
// Shared types and constants for the LM-3 DDRAM port arbiter.
package ddram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RD,
        DONE
    } arb_state_e;

    localparam int NPORT = 4;

    localparam logic [1:0] PORT_MCR      = 2'd0;
    localparam logic [1:0] PORT_SDRAM    = 2'd1;
    localparam logic [1:0] PORT_VRAM_CPU = 2'd2;
    localparam logic [1:0] PORT_VGA      = 2'd3;

    // Successor within the round-robin ring of ports 0..2.
    function automatic logic [1:0] next_port3(input logic [1:0] p);
        return (p >= PORT_VRAM_CPU) ? PORT_MCR : p + 2'd1;
    endfunction

endpackage

// File: rtl/ddram_port_arbiter_rr_pick3.sv
// Combinational round-robin picker over ports 0..2, searching upward from ptr_i with wrap.
module rr_pick3
    import ddram_arb_pkg::*;
(
    input  logic [2:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [1:0] idx_o,
    output logic       valid_o
);

    logic [1:0] cand;

    always_comb begin
        idx_o   = PORT_MCR;
        valid_o = 1'b0;
        cand    = (ptr_i > PORT_VRAM_CPU) ? PORT_MCR : ptr_i;
        for (int unsigned i = 0; i < 3; i++) begin
            if (!valid_o && req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
            cand = next_port3(cand);
        end
    end

endmodule

// File: rtl/ddram_port_arbiter.sv
// Shares the single DDRAM port among microcode, main memory, CPU VRAM and VGA refresh
// requesters; one single-beat read or write in flight at a time.
module ddram_port_arbiter
    import ddram_arb_pkg::*;
#(
    parameter int ADDR_W  = 29,
    parameter int DATA_W  = 64,
    parameter int VGA_RUN = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,

    input  logic [3:0]                req,
    input  logic [3:0]                req_we,
    input  logic [4*ADDR_W-1:0]       req_addr,
    input  logic [4*DATA_W-1:0]       req_wdata,
    input  logic [4*(DATA_W/8)-1:0]   req_be,
    output logic [3:0]                grant,
    output logic [3:0]                done,
    output logic [DATA_W-1:0]         rdata,

    output logic                      DDRAM_CLK,
    input  logic                      DDRAM_BUSY,
    output logic [7:0]                DDRAM_BURSTCNT,
    output logic [ADDR_W-1:0]         DDRAM_ADDR,
    output logic                      DDRAM_RD,
    output logic                      DDRAM_WE,
    output logic [DATA_W-1:0]         DDRAM_DIN,
    output logic [DATA_W/8-1:0]       DDRAM_BE,
    input  logic [DATA_W-1:0]         DDRAM_DOUT,
    input  logic                      DDRAM_DOUT_READY
);

    localparam int BE_W  = DATA_W / 8;
    localparam int RUN_W = $clog2(VGA_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(VGA_RUN);

    arb_state_e        state_q,   state_d;
    logic [3:0]        grant_q,   grant_d;
    logic [1:0]        rr_ptr_q,  rr_ptr_d;
    logic [RUN_W-1:0]  vga_run_q, vga_run_d;
    logic              we_q,      we_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [DATA_W-1:0] wdata_q,   wdata_d;
    logic [BE_W-1:0]   be_q,      be_d;
    logic [DATA_W-1:0] rdata_q,   rdata_d;

    logic [1:0] rr_idx;
    logic       rr_valid;
    logic       others_pending;
    logic       vga_wins;
    logic       arb_go;
    logic [1:0] win_idx;

    rr_pick3 u_rr_pick3 (
        .req_i   (req[2:0]),
        .ptr_i   (rr_ptr_q),
        .idx_o   (rr_idx),
        .valid_o (rr_valid)
    );

    // VGA normally wins, but yields once its run limit is reached and someone else waits.
    assign others_pending = |req[2:0];
    assign vga_wins       = req[PORT_VGA] && !((vga_run_q == RUN_MAX) && others_pending);
    assign arb_go         = vga_wins || rr_valid;
    assign win_idx        = vga_wins ? PORT_VGA : rr_idx;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        vga_run_d = vga_run_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        rdata_d   = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (!others_pending) begin
                    vga_run_d = '0;
                end
                if (arb_go) begin
                    we_d    = req_we[win_idx];
                    addr_d  = req_addr[win_idx*ADDR_W +: ADDR_W];
                    wdata_d = req_wdata[win_idx*DATA_W +: DATA_W];
                    be_d    = req_be[win_idx*BE_W +: BE_W];
                    grant_d = 4'b0001 << win_idx;
                    state_d = ISSUE;
                    if (vga_wins) begin
                        if (others_pending && (vga_run_q != RUN_MAX)) begin
                            vga_run_d = vga_run_q + RUN_W'(1);
                        end
                    end else begin
                        vga_run_d = '0;
                        rr_ptr_d  = next_port3(rr_idx);
                    end
                end
            end
            ISSUE: begin
                if (!DDRAM_BUSY) begin
                    state_d = we_q ? DONE : WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (DDRAM_DOUT_READY) begin
                    rdata_d = DDRAM_DOUT;
                    state_d = DONE;
                end
            end
            DONE: begin
                grant_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            vga_run_q <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            vga_run_q <= vga_run_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            rdata_q   <= rdata_d;
        end
    end

    assign grant          = grant_q;
    assign done           = (state_q == DONE) ? grant_q : '0;
    assign rdata          = rdata_q;
    assign DDRAM_CLK      = clk;
    assign DDRAM_BURSTCNT = 8'd1;
    assign DDRAM_RD       = (state_q == ISSUE) && !we_q;
    assign DDRAM_WE       = (state_q == ISSUE) &&  we_q;
    assign DDRAM_ADDR     = addr_q;
    assign DDRAM_DIN      = wdata_q;
    assign DDRAM_BE       = be_q;

endmodule

// File: tb/tb_ddram_port_arbiter.sv
// Self-checking bench for ddram_port_arbiter: directed scenarios plus randomized traffic
// checked against an arbitration model kept in the bench.
module tb_ddram_port_arbiter;

    localparam int AW = 29;
    localparam int DW = 64;
    localparam int BW = DW / 8;
    localparam int VR = 4;

    logic              clk;
    logic              reset_n;
    logic [3:0]        req, req_we;
    logic [4*AW-1:0]   req_addr;
    logic [4*DW-1:0]   req_wdata;
    logic [4*BW-1:0]   req_be;
    logic [3:0]        grant, done;
    logic [DW-1:0]     rdata;
    logic              ddram_clk, busy, rd, we, rdy;
    logic [7:0]        burstcnt;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     din, dout;
    logic [BW-1:0]     be;

    int passed = 0;
    int total  = 0;
    int m_rr   = 0;
    int m_vrun = 0;

    ddram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .VGA_RUN(VR)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req              (req),
        .req_we           (req_we),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .req_be           (req_be),
        .grant            (grant),
        .done             (done),
        .rdata            (rdata),
        .DDRAM_CLK        (ddram_clk),
        .DDRAM_BUSY       (busy),
        .DDRAM_BURSTCNT   (burstcnt),
        .DDRAM_ADDR       (addr),
        .DDRAM_RD         (rd),
        .DDRAM_WE         (we),
        .DDRAM_DIN        (din),
        .DDRAM_BE         (be),
        .DDRAM_DOUT       (dout),
        .DDRAM_DOUT_READY (rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arbitration rules: VGA first unless its run is exhausted with others waiting,
    // else first pending of 0..2 from the rotating start point.
    function automatic int pick(input logic [3:0] p);
        logic others;
        others = p[0] | p[1] | p[2];
        if (p[3] && !(m_vrun == VR && others)) begin
            m_vrun = others ? ((m_vrun < VR) ? m_vrun + 1 : VR) : 0;
            return 3;
        end
        for (int k = 0; k < 3; k++) begin
            if (p[(m_rr + k) % 3]) begin
                int w;
                w      = (m_rr + k) % 3;
                m_rr   = (w + 1) % 3;
                m_vrun = 0;
                return w;
            end
        end
        return -1;
    endfunction

    task automatic clear_inputs();
        req       = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        busy      = 1'b0;
        rdy       = 1'b0;
        dout      = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        m_rr    = 0;
        m_vrun  = 0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({grant, done, rd, we} !== 10'b0)
            $display("FAIL reset_ctrl: got grant=%b done=%b rd=%b we=%b want all 0", grant, done, rd, we);
        else passed++;
        total++;
        if ({rdata, addr, din, be} !== '0)
            $display("FAIL reset_data: got rdata=%h addr=%h din=%h be=%h want 0", rdata, addr, din, be);
        else passed++;
        total++;
        if (burstcnt !== 8'd1 || ddram_clk !== clk)
            $display("FAIL reset_const: got burstcnt=%0d ddram_clk=%b want 1 and %b", burstcnt, ddram_clk, clk);
        else passed++;
        reset_n = 1'b1;
    endtask

    task automatic test_read();
        req_we[1]           = 1'b0;
        req_addr[AW +: AW]  = 29'h0000123;
        req                 = 4'b0010;
        @(negedge clk);
        total++;
        if (grant !== 4'b0010 || rd !== 1'b1 || we !== 1'b0 || addr !== 29'h0000123)
            $display("FAIL read_issue: got grant=%b rd=%b we=%b addr=%h want 0010 1 0 0000123", grant, rd, we, addr);
        else passed++;
        @(negedge clk);
        total++;
        if (rd !== 1'b0 || done !== 4'b0)
            $display("FAIL read_rd_width: got rd=%b done=%b want 0 0000", rd, done);
        else passed++;
        @(negedge clk);
        rdy  = 1'b1;
        dout = 64'hDEADBEEF_CAFEF00D;
        @(negedge clk);
        rdy  = 1'b0;
        dout = '0;
        total++;
        if (done !== 4'b0010 || rdata !== 64'hDEADBEEF_CAFEF00D)
            $display("FAIL read_done: got done=%b rdata=%h want 0010 deadbeefcafef00d", done, rdata);
        else passed++;
        req = '0;
        @(negedge clk);
        total++;
        if (done !== 4'b0 || grant !== 4'b0 || rdata !== 64'hDEADBEEF_CAFEF00D)
            $display("FAIL read_after: got done=%b grant=%b rdata=%h want 0 0 deadbeefcafef00d", done, grant, rdata);
        else passed++;
    endtask

    task automatic test_write_busy();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [BW-1:0] b;
        a = 29'h0ABCDEF;
        d = 64'h01234567_89ABCDEF;
        b = 8'hA5;
        req_we[0]          = 1'b1;
        req_addr[0 +: AW]  = a;
        req_wdata[0 +: DW] = d;
        req_be[0 +: BW]    = b;
        req                = 4'b0001;
        busy               = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++;
            if ({we, rd, addr, din, be, done} !== {1'b1, 1'b0, a, d, b, 4'b0})
                $display("FAIL write_hold[%0d]: got we=%b rd=%b addr=%h din=%h be=%h done=%b want 1 0 %h %h %h 0000",
                         i, we, rd, addr, din, be, done, a, d, b);
            else passed++;
            if (i == 5) busy = 1'b0;
        end
        @(negedge clk);
        total++;
        if (done !== 4'b0001 || we !== 1'b0 || rd !== 1'b0)
            $display("FAIL write_done: got done=%b we=%b rd=%b want 0001 0 0", done, we, rd);
        else passed++;
        req = '0;
        @(negedge clk);
        total++;
        if (done !== 4'b0 || grant !== 4'b0)
            $display("FAIL write_after: got done=%b grant=%b want 0 0", done, grant);
        else passed++;
    endtask

    task automatic test_round_robin();
        int exp_seq[6] = '{0, 1, 2, 0, 1, 2};
        logic [3:0] eg;
        do_reset();
        req_we = 4'b1111;
        req    = 4'b0111;
        for (int t = 0; t < 6; t++) begin
            eg = 4'b0001 << exp_seq[t];
            @(negedge clk);
            total++;
            if (grant !== eg)
                $display("FAIL rr_grant[%0d]: got %b want %b", t, grant, eg);
            else passed++;
            @(negedge clk);
            total++;
            if (done !== eg)
                $display("FAIL rr_done[%0d]: got %b want %b", t, done, eg);
            else passed++;
            @(negedge clk);
        end
        req = '0;
    endtask

    task automatic test_vga_run();
        int exp_seq[10] = '{3, 3, 3, 3, 1, 3, 3, 3, 3, 1};
        logic [3:0] eg;
        do_reset();
        req_we = 4'b1111;
        req    = 4'b1010;
        for (int t = 0; t < 10; t++) begin
            eg = 4'b0001 << exp_seq[t];
            @(negedge clk);
            total++;
            if (grant !== eg)
                $display("FAIL vga_grant[%0d]: got %b want %b", t, grant, eg);
            else passed++;
            @(negedge clk);
            @(negedge clk);
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_drop_mid_flight();
        int n2;
        n2 = 0;
        req_we[2]             = 1'b0;
        req_addr[2*AW +: AW]  = 29'h1555AAA;
        req                   = 4'b0100;
        @(negedge clk);
        n2 += int'(done[2]);
        total++;
        if (grant !== 4'b0100 || rd !== 1'b1)
            $display("FAIL drop_issue: got grant=%b rd=%b want 0100 1", grant, rd);
        else passed++;
        @(negedge clk);
        n2 += int'(done[2]);
        req                   = 4'b0010;
        req_we[1]             = 1'b1;
        req_addr[AW +: AW]    = 29'h0777777;
        @(negedge clk);
        n2 += int'(done[2]);
        total++;
        if (grant !== 4'b0100 || done !== 4'b0)
            $display("FAIL drop_wait: got grant=%b done=%b want 0100 0000", grant, done);
        else passed++;
        rdy  = 1'b1;
        dout = 64'h5A5A_0F0F_1234_8765;
        @(negedge clk);
        n2 += int'(done[2]);
        rdy  = 1'b0;
        total++;
        if (done !== 4'b0100 || rdata !== 64'h5A5A_0F0F_1234_8765)
            $display("FAIL drop_done: got done=%b rdata=%h want 0100 5a5a0f0f12348765", done, rdata);
        else passed++;
        @(negedge clk);
        n2 += int'(done[2]);
        @(negedge clk);
        n2 += int'(done[2]);
        total++;
        if (grant !== 4'b0010 || we !== 1'b1 || addr !== 29'h0777777)
            $display("FAIL drop_next: got grant=%b we=%b addr=%h want 0010 1 0777777", grant, we, addr);
        else passed++;
        @(negedge clk);
        n2 += int'(done[2]);
        total++;
        if (done !== 4'b0010)
            $display("FAIL drop_next_done: got %b want 0010", done);
        else passed++;
        req = '0;
        @(negedge clk);
        total++;
        if (n2 !== 1)
            $display("FAIL drop_pulses: got %0d done[2] pulses want 1", n2);
        else passed++;
    endtask

    task automatic test_random();
        logic [3:0]    pend;
        logic          fwe[4];
        logic [AW-1:0] fa[4];
        logic [DW-1:0] fd[4];
        logic [BW-1:0] fb[4];
        logic [DW-1:0] last, d;
        logic [3:0]    eg;
        int            w, busy_n, lat, p;
        do_reset();
        last = '0;
        pend = '0;
        for (int i = 0; i < 4; i++) begin
            fwe[i] = 1'($urandom_range(0, 1));
            fa[i]  = AW'($urandom);
            fd[i]  = {$urandom, $urandom};
            fb[i]  = BW'($urandom);
            pend[i] = 1'($urandom_range(0, 1));
        end
        if (pend == '0) pend = 4'b1000;
        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < 4; i++) begin
                req_we[i]               = fwe[i];
                req_addr[i*AW +: AW]    = fa[i];
                req_wdata[i*DW +: DW]   = fd[i];
                req_be[i*BW +: BW]      = fb[i];
            end
            req    = pend;
            w      = pick(pend);
            eg     = 4'b0001 << w;
            busy_n = $urandom_range(0, 3);
            for (int c = 0; c <= busy_n; c++) begin
                @(negedge clk);
                total++;
                if ({grant, rd, we, addr, din, be, done} !== {eg, !fwe[w], fwe[w], fa[w], fd[w], fb[w], 4'b0})
                    $display("FAIL rand_issue[%0d]: got g=%b rd=%b we=%b addr=%h din=%h be=%h done=%b want g=%b we=%b addr=%h din=%h be=%h",
                             t, grant, rd, we, addr, din, be, done, eg, fwe[w], fa[w], fd[w], fb[w]);
                else passed++;
                busy = (c < busy_n);
                rdy  = 1'($urandom_range(0, 1));
                dout = {$urandom, $urandom};
            end
            @(negedge clk);
            busy = 1'b0;
            rdy  = 1'b0;
            if (!fwe[w]) begin
                lat = $urandom_range(0, 3);
                for (int k = 0; k < lat; k++) begin
                    total++;
                    if ({rd, we, done} !== 6'b0)
                        $display("FAIL rand_wait[%0d]: got rd=%b we=%b done=%b want 0 0 0000", t, rd, we, done);
                    else passed++;
                    @(negedge clk);
                end
                d    = {$urandom, $urandom};
                rdy  = 1'b1;
                dout = d;
                @(negedge clk);
                rdy  = 1'b0;
                last = d;
            end
            total++;
            if (done !== eg || rdata !== last || rd !== 1'b0 || we !== 1'b0)
                $display("FAIL rand_done[%0d]: got done=%b rdata=%h rd=%b we=%b want %b %h 0 0",
                         t, done, rdata, rd, we, eg, last);
            else passed++;
            pend[w] = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && $urandom_range(0, 3) < ((i == 3) ? 3 : 1)) begin
                    pend[i] = 1'b1;
                    fwe[i]  = 1'($urandom_range(0, 1));
                    fa[i]   = AW'($urandom);
                    fd[i]   = {$urandom, $urandom};
                    fb[i]   = BW'($urandom);
                end
            end
            if (pend == '0) begin
                p       = $urandom_range(0, 3);
                pend[p] = 1'b1;
                fwe[p]  = 1'($urandom_range(0, 1));
                fa[p]   = AW'($urandom);
            end
            @(negedge clk);
            total++;
            if (grant !== 4'b0 || done !== 4'b0)
                $display("FAIL rand_idle[%0d]: got grant=%b done=%b want 0 0", t, grant, done);
            else passed++;
        end
        req = '0;
    endtask

    task automatic test_async_reset();
        req_we[0]          = 1'b0;
        req_addr[0 +: AW]  = 29'h1FEDCBA;
        req_wdata[0 +: DW] = 64'hFFFF_0000_FFFF_0000;
        req_be[0 +: BW]    = 8'hFF;
        req                = 4'b0001;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (grant !== 4'b0001 || rd !== 1'b0)
            $display("FAIL areset_pre: got grant=%b rd=%b want 0001 0", grant, rd);
        else passed++;
        #3 reset_n = 1'b0;
        #1;
        total++;
        if ({grant, done, rd, we} !== 10'b0 || {rdata, addr, din, be} !== '0)
            $display("FAIL areset_now: got grant=%b done=%b rd=%b we=%b rdata=%h addr=%h din=%h be=%h want all 0",
                     grant, done, rd, we, rdata, addr, din, be);
        else passed++;
        req = '0;
        @(negedge clk);
        reset_n = 1'b1;
        rdy     = 1'b1;
        dout    = 64'h1111_2222_3333_4444;
        @(negedge clk);
        rdy = 1'b0;
        total++;
        if (done !== 4'b0 || rdata !== '0)
            $display("FAIL areset_stray: got done=%b rdata=%h want 0000 0", done, rdata);
        else passed++;
        @(negedge clk);
        total++;
        if (done !== 4'b0 || grant !== 4'b0)
            $display("FAIL areset_after: got done=%b grant=%b want 0 0", done, grant);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_busy();
        test_round_robin();
        test_vga_run();
        test_drop_mid_flight();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
